// File: rtl/hough_vote_scheduler.sv
// hough_vote_scheduler
//   Scores one circle-centre candidate at a time against a Hough accumulator
//   held in BRAM. The scheduler visits 8 ring points around the candidate,
//   one per cycle, and counts how many accumulator reads come back non-zero.
//   It keeps the best-scoring candidate of the current frame.
//
//   Handshake: a candidate transfers in a cycle where cand_valid and
//   cand_ready are both 1. cand_ready is 1 only in IDLE while frame_start is
//   low and rst is low. A source whose cand_valid is refused must hold the
//   candidate until it is accepted.
//
//   Timing: the accept cycle is cycle 0. ISSUE covers cycles 1..8, DRAIN
//   covers the next RD_LAT cycles, and DECIDE is one cycle after that. IDLE
//   comes back in cycle 10+RD_LAT.
//
//   Ports
//     clk, rst            clock, asynchronous active-high reset
//     frame_start         new-frame pulse: clears best, aborts evaluation
//     cand_valid/ready    candidate handshake, cand_x[9:0], cand_y[8:0]
//     rd_en, rd_addr      accumulator BRAM read request (18-bit word address)
//     rd_data             BRAM read data, valid RD_LAT cycles after rd_en
//     best_valid/x/y/score best candidate of the frame so far
//     busy                1 in every state other than IDLE
//     stateDbg            current FSM state (0 IDLE,1 ISSUE,2 DRAIN,3 DECIDE)
//
//   Build option: HOUGH_TIE_LATEST_EN. When this macro is defined, a
//   candidate whose score equals the current best score replaces the best
//   entry. By default, the earlier entry is kept on a tie.
module hough_vote_scheduler #(
   parameter int RADIUS     = 4,
   parameter int ROW_LENGTH = 450,
   parameter int COL_LENGTH = 290,
   parameter int BIAS       = 95,
   parameter int THRESH     = 7,
   parameter int RD_LAT     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        cand_valid,
   output logic        cand_ready,
   input  logic [9:0]  cand_x,
   input  logic [8:0]  cand_y,
   output logic        rd_en,
   output logic [17:0] rd_addr,
   input  logic [3:0]  rd_data,
   output logic        best_valid,
   output logic [9:0]  best_x,
   output logic [8:0]  best_y,
   output logic [3:0]  best_score,
   output logic        busy,
   output logic [1:0]  stateDbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DECIDE = 2'd3} stateT;

   localparam logic signed [10:0] R11    = 11'(RADIUS);
   localparam logic signed [10:0] B11    = 11'(BIAS);
   localparam logic signed [10:0] XLIM11 = 11'(ROW_LENGTH + BIAS);
   localparam logic signed [10:0] YLIM11 = 11'(COL_LENGTH + BIAS);
   localparam logic [17:0]        ROW18  = 18'(ROW_LENGTH);
   localparam logic [3:0]         THR4   = 4'(THRESH);
   localparam logic [2:0]         DLAST  = 3'(RD_LAT - 1);

   stateT              state, nextState;
   logic [9:0]         candX;
   logic [8:0]         candY;
   logic [2:0]         slotIdx;
   logic [2:0]         drainCnt;
   logic [3:0]         voteCnt;
   // The current-cycle issue (issueNow) plus these RD_LAT registered stages
   // form the 1+RD_LAT-deep valid pipeline. The last stage lines up with
   // rd_data for that read.
   logic [RD_LAT-1:0]  pendPipe;

   logic signed [10:0] dx, dy, px, py, pxOff, pyOff;
   logic               inWindow, issueNow, transfer, winner;

   // Ring offsets in the fixed visiting order.
   always_comb begin
      dx = '0;
      dy = '0;
      case (slotIdx)
         3'd0: dx = -R11;
         3'd1: dx = R11;
         3'd2: dy = -R11;
         3'd3: dy = R11;
         3'd4: begin dx = -R11; dy = -R11; end
         3'd5: begin dx = R11;  dy = -R11; end
         3'd6: begin dx = -R11; dy = R11;  end
         default: begin dx = R11; dy = R11; end
      endcase
   end

   // Signed 11-bit arithmetic means any point left of or above the origin
   // compares as out-of-window.
   assign px       = $signed({1'b0, candX}) + dx;
   assign py       = $signed({2'b00, candY}) + dy;
   assign pxOff    = px - B11;
   assign pyOff    = py - B11;
   assign inWindow = (px >= B11) && (px < XLIM11) && (py >= B11) && (py < YLIM11);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      if (frame_start) begin
         nextState = IDLE;
      end else begin
         case (state)
            IDLE:    if (transfer) nextState = ISSUE;
            ISSUE:   if (slotIdx == 3'd7) nextState = DRAIN;
            DRAIN:   if (drainCnt == DLAST) nextState = DECIDE;
            default: nextState = IDLE;
         endcase
      end
   end

   // Output logic
   always_comb begin
      cand_ready = (state == IDLE) && !frame_start && !rst;
      busy       = (state != IDLE);
      issueNow   = (state == ISSUE) && inWindow && !frame_start;
      rd_en      = issueNow;
      rd_addr    = issueNow ? (18'(pxOff) + 18'(pyOff) * ROW18) : '0;
      stateDbg   = state;
   end

   assign transfer = cand_valid && cand_ready;

`ifdef HOUGH_TIE_LATEST_EN
   assign winner = (voteCnt >= THR4) && (!best_valid || (voteCnt >= best_score));
`else
   assign winner = (voteCnt >= THR4) && (!best_valid || (voteCnt > best_score));
`endif

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         candX      <= '0;
         candY      <= '0;
         slotIdx    <= '0;
         drainCnt   <= '0;
         voteCnt    <= '0;
         pendPipe   <= '0;
         best_valid <= 1'b0;
         best_x     <= '0;
         best_y     <= '0;
         best_score <= '0;
      end else begin
         // Clearing the pipeline on frame_start discards late returns from
         // the aborted candidate.
         if (frame_start) begin
            pendPipe <= '0;
         end else begin
            for (int i = RD_LAT - 1; i > 0; i--) pendPipe[i] <= pendPipe[i-1];
            pendPipe[0] <= issueNow;
         end

         if (transfer) begin
            candX   <= cand_x;
            candY   <= cand_y;
            slotIdx <= '0;
            voteCnt <= '0;
         end else begin
            if (state == ISSUE) slotIdx <= slotIdx + 3'd1;
            if (pendPipe[RD_LAT-1] && (rd_data != 4'd0) && (voteCnt < 4'd8))
               voteCnt <= voteCnt + 4'd1;
         end

         if (state == ISSUE)      drainCnt <= '0;
         else if (state == DRAIN) drainCnt <= drainCnt + 3'd1;

         if (frame_start) begin
            best_valid <= 1'b0;
            best_x     <= '0;
            best_y     <= '0;
            best_score <= '0;
         end else if ((state == DECIDE) && winner) begin
            best_valid <= 1'b1;
            best_x     <= candX;
            best_y     <= candY;
            best_score <= voteCnt;
         end
      end
   end

endmodule
